// File: rtl/axis_uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axis_uart_pkg
// Purpose  : Shared FSM state encoding, parity-mode codes and divider helper
//            for the AXI-Stream UART transmit framer.
// Revision : 1.0 - initial release
// ============================================================================
package axis_uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t c_ST_IDLE  = 3'd0;
    localparam tx_state_t c_ST_START = 3'd1;
    localparam tx_state_t c_ST_DATA  = 3'd2;
    localparam tx_state_t c_ST_PAR   = 3'd3;
    localparam tx_state_t c_ST_STOP  = 3'd4;

    localparam logic [1:0] c_PAR_NONE = 2'd0;
    localparam logic [1:0] c_PAR_EVEN = 2'd1;
    localparam logic [1:0] c_PAR_ODD  = 2'd2;

    // Zero selects the build-time default; anything below 2 is clamped to 2.
    function automatic logic [15:0] eff_div(input logic [15:0] baud_div,
                                            input logic [15:0] default_div);
        logic [15:0] v;
        v = (baud_div == 16'd0) ? default_div : baud_div;
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_byte_shifter
// Purpose  : Serialises one byte per handshake: start, 8 data bits LSB-first,
//            optional parity and 1-2 stop bits, each lasting DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte_shifter
    import axis_uart_pkg::*;
#(
    parameter logic [1:0]  PAR_MODE    = c_PAR_NONE,
    parameter int          STOP_BITS   = 1,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_baud_div,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_byte_done,
    output logic        o_idle,
    output logic        o_tx
);

    tx_state_t   r_state;
    logic [15:0] r_div;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shreg;
    logic        r_par_bit;
    logic        r_stop_cnt;
    logic        r_tx;

    logic w_bit_end;
    logic w_last_stop;
    logic w_take;

    assign w_bit_end    = (r_baud_cnt == (r_div - 16'd1));
    assign w_last_stop  = (STOP_BITS == 1) || r_stop_cnt;
    assign o_byte_done  = (r_state == c_ST_STOP) && w_bit_end && w_last_stop;
    // Ready on the final stop clock too, so the next start bit follows with no gap.
    assign o_byte_ready = (r_state == c_ST_IDLE) || o_byte_done;
    assign w_take       = i_byte_valid && o_byte_ready;
    assign o_idle       = (r_state == c_ST_IDLE);
    assign o_tx         = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_div      <= 16'd2;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'd0;
            r_par_bit  <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_take) begin
            r_state    <= c_ST_START;
            r_div      <= eff_div(i_baud_div, DEFAULT_DIV);
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= i_byte_data;
            r_par_bit  <= (PAR_MODE == c_PAR_ODD) ? ~(^i_byte_data) : ^i_byte_data;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b0;
        end else if (r_state != c_ST_IDLE) begin
            if (!w_bit_end) begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end else begin
                r_baud_cnt <= 16'd0;
                case (r_state)
                    c_ST_START: begin
                        r_state <= c_ST_DATA;
                        r_tx    <= r_shreg[0];
                    end
                    c_ST_DATA: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
                            if (PAR_MODE != c_PAR_NONE) begin
                                r_state <= c_ST_PAR;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= c_ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shreg   <= {1'b0, r_shreg[7:1]};
                            r_tx      <= r_shreg[1];
                        end
                    end
                    c_ST_PAR: begin
                        r_state <= c_ST_STOP;
                        r_tx    <= 1'b1;
                    end
                    c_ST_STOP: begin
                        if (w_last_stop) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_uart_tx_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axis_uart_tx_framer
// Purpose  : AXI-Stream to UART transmitter with holding + shift word stages,
//            TKEEP byte skipping and a completed-byte counter.
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_tx_framer
    import axis_uart_pkg::*;
#(
    parameter int    UART_SPEED = 115200,
    parameter int    FREQ_HZ    = 100000000,
    parameter int    N_BYTES    = 32,
    parameter string PARITY     = "none",
    parameter int    STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic [N_BYTES-1:0]   S_AXIS_TKEEP,
    input  logic                 S_AXIS_TVALID,
    output logic                 S_AXIS_TREADY,
    input  logic [15:0]          BAUD_DIV,
    output logic                 UART_TX,
    output logic                 BUSY,
    output logic [31:0]          TX_BYTE_CNT
);

    localparam logic [1:0]  c_PAR_MODE    = (PARITY == "even") ? c_PAR_EVEN :
                                            (PARITY == "odd")  ? c_PAR_ODD  : c_PAR_NONE;
    localparam logic [15:0] c_DEFAULT_DIV = 16'(FREQ_HZ / UART_SPEED);

    logic                 r_ready_en;
    logic                 r_hold_valid;
    logic [N_BYTES*8-1:0] r_hold_data;
    logic [N_BYTES-1:0]   r_hold_keep;
    logic [N_BYTES*8-1:0] r_word_data;
    logic [N_BYTES-1:0]   r_word_keep;
    logic [31:0]          r_tx_byte_cnt;

    logic                 w_accept;
    logic [N_BYTES-1:0]   w_take_onehot;
    logic [N_BYTES-1:0]   w_keep_after;
    logic [7:0]           w_byte_data;
    logic                 w_byte_valid;
    logic                 w_byte_ready;
    logic                 w_byte_done;
    logic                 w_shift_idle;
    logic                 w_load_word;

    // r_ready_en holds TREADY low through reset and for the first edge after it.
    assign S_AXIS_TREADY = r_ready_en && !r_hold_valid;
    assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_byte_valid  = |r_word_keep;
    assign w_take_onehot = r_word_keep & (~r_word_keep + N_BYTES'(1));
    assign w_keep_after  = (w_byte_valid && w_byte_ready) ? (r_word_keep & ~w_take_onehot)
                                                          : r_word_keep;
    assign w_load_word   = r_hold_valid && (w_keep_after == '0);
    assign BUSY          = !(w_shift_idle && !r_hold_valid && (r_word_keep == '0));
    assign TX_BYTE_CNT   = r_tx_byte_cnt;

    always_comb begin
        w_byte_data = 8'd0;
        for (int i = 0; i < N_BYTES; i++) begin
            if (w_take_onehot[i]) begin
                w_byte_data = r_word_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready_en    <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_data   <= '0;
            r_hold_keep   <= '0;
            r_word_data   <= '0;
            r_word_keep   <= '0;
            r_tx_byte_cnt <= 32'd0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= S_AXIS_TDATA;
                r_hold_keep  <= S_AXIS_TKEEP;
            end else if (w_load_word) begin
                r_hold_valid <= 1'b0;
            end
            // An all-zero TKEEP word passes through here and is dropped silently.
            if (w_load_word) begin
                r_word_data <= r_hold_data;
                r_word_keep <= r_hold_keep;
            end else begin
                r_word_keep <= w_keep_after;
            end
            if (w_byte_done) begin
                r_tx_byte_cnt <= r_tx_byte_cnt + 32'd1;
            end
        end
    end

    uart_tx_byte_shifter #(
        .PAR_MODE    (c_PAR_MODE),
        .STOP_BITS   (STOP_BITS),
        .DEFAULT_DIV (c_DEFAULT_DIV)
    ) u_shifter (
        .clk          (clk),
        .rst          (reset),
        .i_baud_div   (BAUD_DIV),
        .i_byte_valid (w_byte_valid),
        .i_byte_data  (w_byte_data),
        .o_byte_ready (w_byte_ready),
        .o_byte_done  (w_byte_done),
        .o_idle       (w_shift_idle),
        .o_tx         (UART_TX)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_uart_tx_framer
// Purpose  : Self-checking bench: byte scoreboard on the no-parity instance,
//            directed frame captures on even/odd parity instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_uart_tx_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tv_n, tv_e, tv_o;
    logic [15:0] baud_div;
    logic        tr_n, tr_e, tr_o;
    logic        tx_n, tx_e, tx_o;
    logic        busy_n, busy_e, busy_o;
    logic [31:0] cnt_n, cnt_e, cnt_o;

    always #5 clk = ~clk;

    axis_uart_tx_framer #(.UART_SPEED(10000000), .FREQ_HZ(100000000), .N_BYTES(4),
                          .PARITY("none"), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TVALID(tv_n), .S_AXIS_TREADY(tr_n), .BAUD_DIV(baud_div),
        .UART_TX(tx_n), .BUSY(busy_n), .TX_BYTE_CNT(cnt_n));

    axis_uart_tx_framer #(.UART_SPEED(10000000), .FREQ_HZ(100000000), .N_BYTES(4),
                          .PARITY("even"), .STOP_BITS(2)) dut_e (
        .clk(clk), .reset(reset), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TVALID(tv_e), .S_AXIS_TREADY(tr_e), .BAUD_DIV(baud_div),
        .UART_TX(tx_e), .BUSY(busy_e), .TX_BYTE_CNT(cnt_e));

    axis_uart_tx_framer #(.UART_SPEED(10000000), .FREQ_HZ(100000000), .N_BYTES(4),
                          .PARITY("odd"), .STOP_BITS(1)) dut_o (
        .clk(clk), .reset(reset), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TVALID(tv_o), .S_AXIS_TREADY(tr_o), .BAUD_DIV(baud_div),
        .UART_TX(tx_o), .BUSY(busy_o), .TX_BYTE_CNT(cnt_o));

    typedef struct {
        logic [7:0] d;
        int         div;
    } exp_t;

    exp_t sb_q[$];
    int   start_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    logic mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every frame on the no-parity line is checked cycle by cycle.
    initial begin : monitor
        exp_t       e;
        int         bad;
        int         b;
        logic       lvl;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (mon_en && tx_n === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    for (int t = 0; t < 2000 && tx_n !== 1'b1; t++) @(negedge clk);
                end else begin
                    e = sb_q.pop_front();
                    start_cyc.push_back(cyc);
                    bad = 0;
                    got = 8'd0;
                    for (int n = 0; n < 10 * e.div; n++) begin
                        if (n > 0) @(negedge clk);
                        b = n / e.div;
                        if (b == 0)      lvl = 1'b0;
                        else if (b == 9) lvl = 1'b1;
                        else             lvl = e.d[b-1];
                        if (tx_n !== lvl) bad++;
                        if (b >= 1 && b <= 8 && (n % e.div) == e.div / 2) got[b-1] = tx_n;
                    end
                    check("frame_data", {24'd0, got}, {24'd0, e.d});
                    check("frame_bad_cycles", bad, 0);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input int div0,
                        input int div1, input bit push, output int hs);
        bit first = 1'b1;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (k[i]) begin
                    exp_t e;
                    e.d   = d[8*i +: 8];
                    e.div = first ? div0 : div1;
                    first = 1'b0;
                    sb_q.push_back(e);
                    exp_cnt++;
                end
            end
        end
        @(negedge clk);
        tdata = d;
        tkeep = k;
        tv_n  = 1'b1;
        hs    = -1;
        for (int t = 0; t < 3000; t++) begin
            if (tr_n === 1'b1) begin
                hs = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (hs < 0) check("handshake_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        #1 tv_n = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        for (t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (busy_n === 1'b0 && sb_q.size() == 0) break;
        end
        check(tag, {31'd0, t < 20000}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_line_low(input bit odd_inst, input string tag);
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if ((odd_inst ? tx_o : tx_e) === 1'b0) break;
        end
        check(tag, {31'd0, t < 100}, 32'd1);
    endtask

    task automatic par_frame(input bit odd_inst, input logic [7:0] b, input logic [11:0] exp_bits,
                             input int nbits, input string tag);
        logic [11:0] bits = 12'd0;
        logic [31:0] c_before = 32'hFFFF_FFFF;
        logic [31:0] c_after  = 32'hFFFF_FFFF;
        logic        lv;
        int          t;
        @(negedge clk);
        tdata = {24'd0, b};
        tkeep = 4'b0001;
        if (odd_inst) tv_o = 1'b1; else tv_e = 1'b1;
        for (t = 0; t < 100; t++) begin
            if ((odd_inst ? tr_o : tr_e) === 1'b1) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 tv_o = 1'b0;
        tv_e = 1'b0;
        wait_line_low(odd_inst, {tag, "_start"});
        for (int n = 0; n <= nbits * 10; n++) begin
            if (n > 0) @(negedge clk);
            lv = odd_inst ? tx_o : tx_e;
            if (n % 10 == 5) bits[n/10] = lv;
            if (n == nbits * 10 - 1) c_before = odd_inst ? cnt_o : cnt_e;
            if (n == nbits * 10)     c_after  = odd_inst ? cnt_o : cnt_e;
        end
        check({tag, "_bits"}, {20'd0, bits}, {20'd0, exp_bits});
        check({tag, "_cnt_before_end"}, c_before, 32'd0);
        check({tag, "_cnt_at_end"}, c_after, 32'd1);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hs, hs1, hs2, base, bad;
        reset    = 1'b1;
        tdata    = 32'd0;
        tkeep    = 4'd0;
        tv_n     = 1'b0;
        tv_e     = 1'b0;
        tv_o     = 1'b0;
        baud_div = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, tx_n}, 32'd1);
        check("rst_tready", {31'd0, tr_n}, 32'd0);
        check("rst_busy", {31'd0, busy_n}, 32'd0);
        check("rst_cnt", cnt_n, 32'd0);
        reset = 1'b0;
        #1 check("tready_before_edge", {31'd0, tr_n}, 32'd0);
        @(negedge clk);
        check("tready_after_edge", {31'd0, tr_n}, 32'd1);

        // Single byte 0x55, plus idle-to-start latency.
        send(32'h0000_0055, 4'b0001, 10, 10, 1'b1, hs);
        wait_idle("idle_0x55");
        if (start_cyc.size() > 0) check("latency_k_plus_2", start_cyc[0], hs + 2);
        else check("latency_no_frame", 32'd0, 32'd1);
        check("cnt_0x55", cnt_n, exp_cnt);

        // Sparse TKEEP and an empty word.
        base = start_cyc.size();
        send(32'hDDCC_BBAA, 4'b1010, 10, 10, 1'b1, hs);
        wait_idle("idle_keep1010");
        check("keep1010_frames", start_cyc.size() - base, 2);
        check("cnt_keep1010", cnt_n, exp_cnt);
        base = start_cyc.size();
        send(32'h1122_3344, 4'b0000, 10, 10, 1'b1, hs);
        check("keep0_accepted", {31'd0, hs >= 0}, 32'd1);
        repeat (40) @(negedge clk);
        check("keep0_frames", start_cyc.size() - base, 0);
        check("keep0_cnt", cnt_n, exp_cnt);
        check("keep0_busy", {31'd0, busy_n}, 32'd0);

        // Two full words back to back.
        base = start_cyc.size();
        send(32'h4433_2211, 4'b1111, 10, 10, 1'b1, hs1);
        send(32'h8877_6655, 4'b1111, 10, 10, 1'b1, hs2);
        check("tready_during_word1", {31'd0, (hs2 - hs1) < 400}, 32'd1);
        wait_idle("idle_b2b");
        check("b2b_frames", start_cyc.size() - base, 8);
        bad = 0;
        for (int i = 0; base + i + 1 < start_cyc.size(); i++)
            if (start_cyc[base+i+1] - start_cyc[base+i] != 100) bad++;
        check("b2b_gap", bad, 0);
        check("cnt_b2b", cnt_n, exp_cnt);

        // Baud change mid-frame applies from the next byte; 1 behaves as 2.
        base = start_cyc.size();
        send(32'h0000_A53C, 4'b0011, 10, 4, 1'b1, hs);
        for (int t = 0; t < 50 && tx_n !== 1'b0; t++) @(negedge clk);
        repeat (45) @(negedge clk);
        baud_div = 16'd4;
        wait_idle("idle_div4");
        if (start_cyc.size() >= base + 2) check("div_change_first_len", start_cyc[base+1] - start_cyc[base], 100);
        else check("div_change_frames", start_cyc.size() - base, 2);
        baud_div = 16'd1;
        send(32'h0000_005A, 4'b0001, 2, 2, 1'b1, hs);
        wait_idle("idle_div1");
        check("cnt_div", cnt_n, exp_cnt);
        baud_div = 16'd0;

        // Reset during data bit 5 abandons the frame.
        mon_en = 1'b0;
        send(32'h0000_00F0, 4'b0001, 10, 10, 1'b0, hs);
        for (int t = 0; t < 50 && tx_n !== 1'b0; t++) @(negedge clk);
        repeat (65) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_uart_tx", {31'd0, tx_n}, 32'd1);
        check("midrst_cnt", cnt_n, 32'd0);
        check("midrst_busy", {31'd0, busy_n}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en  = 1'b1;
        exp_cnt = 0;
        send(32'h0000_0081, 4'b0001, 10, 10, 1'b1, hs);
        wait_idle("idle_after_rst");
        check("cnt_after_rst", cnt_n, exp_cnt);

        // Parity instances: 0x07 even/2 stop and odd/1 stop.
        par_frame(1'b0, 8'h07, 12'hE0E, 12, "even_2stop");
        par_frame(1'b1, 8'h07, 12'h40E, 11, "odd_1stop");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_uart_tx_framer.md
AXIS_UART_TX_FRAMER -- requirements
Module: axis_uart_tx_framer

Interface
REQ-001 Parameter UART_SPEED, default 115200, default baud rate in bit/s.
REQ-002 Parameter FREQ_HZ, default 100000000, clk frequency in Hz.
REQ-003 Parameter N_BYTES, default 32, S_AXIS word width in bytes (1..64).
REQ-004 Parameter PARITY, default "none", one of "none", "even", "odd".
REQ-005 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-006 Port clk  input  1  the single clock; every register is on its rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port S_AXIS_TDATA  input  N_BYTES*8  payload; byte i is TDATA[8i+7:8i].
REQ-009 Port S_AXIS_TKEEP  input  N_BYTES  per-byte valid mask.
REQ-010 Port S_AXIS_TVALID  input  1  / S_AXIS_TREADY  output  1  AXI-Stream handshake.
REQ-011 Port BAUD_DIV  input  16  runtime clocks-per-bit; 0 selects DEFAULT_DIV = FREQ_HZ/UART_SPEED (integer division).
REQ-012 Port UART_TX  output  1  serial line, idle high.
REQ-013 Port BUSY  output  1  high while a frame is on the line or a word is pending.
REQ-014 Port TX_BYTE_CNT  output  32  count of completed byte frames, wraps at 2^32.

Function
REQ-015 Input acceptance: a word SHALL transfer on any edge with TVALID and TREADY both high; TREADY SHALL equal "holding register empty" and SHALL NOT depend combinationally on TVALID.
REQ-016 Two-stage buffering: a holding register SHALL refill while the shift stage serialises the previous word, so TREADY can be high during transmission.
REQ-017 Byte order: kept bytes SHALL be sent ascending by index; bytes with TKEEP=0 SHALL be skipped with no line activity; a TKEEP=0 word SHALL be consumed silently.
REQ-018 Frame: start bit (0), 8 data bits LSB-first, optional parity bit, STOP_BITS stop bits (1); every bit SHALL last exactly DIV clocks.
REQ-019 Parity: "even" sends XOR of data bits; "odd" sends its inverse; "none" sends no parity bit.
REQ-020 DIV SHALL be sampled once at each byte's start bit; values 1 SHALL be treated as 2; a BAUD_DIV change mid-byte SHALL take effect on the next byte.
REQ-021 States SHALL be IDLE, START, DATA, PAR, STOP; IDLE->START when a kept byte is available; START->DATA; DATA->PAR or STOP after bit 7; PAR->STOP; STOP->START if another kept byte is available, else IDLE.
REQ-022 Latency: with the framer idle, the handshake edge at cycle k SHALL make UART_TX low from cycle k+2.
REQ-023 Back-to-back: when the next kept byte (same or next word) is ready, the next start bit SHALL begin on the clock after the last stop bit, with no idle bit.
REQ-024 TX_BYTE_CNT SHALL increment on the last clock of each byte's final stop bit; UART_TX SHALL be registered.
REQ-025 BUSY SHALL be low only when in IDLE with the holding register empty.

Reset
REQ-026 While reset is high: UART_TX=1, S_AXIS_TREADY=0, BUSY=0, TX_BYTE_CNT=0, state IDLE, both buffers empty, bit counters 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame and drive UART_TX high on the next edge; S_AXIS_TREADY SHALL rise the clock after reset deasserts.

Structure
REQ-028 The state enum and the PARITY encoding SHALL live in the shared package axis_uart_pkg.
REQ-029 Per-byte serialisation (baud counter, bit counter, parity, FSM) SHALL be the sub-module uart_tx_byte_shifter, with a byte valid/ready handshake; the top SHALL hold buffering, TKEEP skipping and TX_BYTE_CNT.

Verification (FREQ_HZ=100e6, UART_SPEED=10e6 -> DEFAULT_DIV=10, N_BYTES=4, BAUD_DIV=0 unless stated)
REQ-030 PARITY "none": TDATA=0x00000055, TKEEP=0001 -> UART_TX low 10 clk, then bits 1,0,1,0,1,0,1,0 at 10 clk each, then high; TX_BYTE_CNT=1 after 100 clk.
REQ-031 PARITY "even", STOP_BITS=2: byte 0x07 -> parity bit 1, two stop bits; frame length 120 clk; "odd" -> parity bit 0.
REQ-032 TDATA=0xDDCCBBAA, TKEEP=1010 -> exactly two frames, 0xBB then 0xDD; TKEEP=0000 -> no line activity, word accepted.
REQ-033 Two full words with TVALID held high -> 8 frames, start bit follows previous stop bit with zero idle clocks; TREADY high again during word 1 transmission.
REQ-034 BAUD_DIV=4 written during bit 3 of a frame -> that frame stays at 10 clk/bit, next frame at 4 clk/bit; BAUD_DIV=1 -> 2 clk/bit.
REQ-035 Reset pulse during DATA bit 5 -> UART_TX=1 next edge, TX_BYTE_CNT=0, BUSY=0; new word after reset transmits normally.
